// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers host words in a circular FIFO and issues them one at a
// time to the UART transmitter, tracking parity retries and recovering hung transfers.
module uart_tx_scheduler #(
  parameter int size      = 32,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 4096
) (
  input  logic                   CLK_Baudin,
  input  logic                   RstSch,
  input  logic [size-1:0]        WrData,
  input  logic                   WrEn,
  input  logic                   ErrClr,
  input  logic                   DoneTx,
  input  logic                   Flag_in,
  output logic [size-1:0]        DataIn,
  output logic                   NewData,
  output logic                   TxRst,
  output logic                   Full,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Busy,
  output logic                   RetryErr,
  output logic                   TimeoutErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [size-1:0] mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic            done_q_r;
  logic            flag_q_r;
  logic [RW-1:0]   retry_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic            pop_s;
  logic            push_s;
  logic            done_rise_s;
  logic            flag_rise_s;
  logic            retry_set_s;

  // Next-state and per-cycle control decode
  always_comb begin
    state_s     = state_r;
    pop_s       = 1'b0;
    retry_set_s = 1'b0;
    done_rise_s = DoneTx & ~done_q_r;
    flag_rise_s = Flag_in & ~flag_q_r;
    case (state_r)
      IDLE: begin
        if (!Empty) begin
          pop_s   = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (flag_rise_s && (retry_cnt_r >= RW'(MAX_RETRY))) begin
          retry_set_s = 1'b1;
        end else begin
          retry_set_s = 1'b0;
        end
        // A stale-high DoneTx from the previous word never forms an edge here
        if (done_rise_s) begin
          state_s = IDLE;
        end else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
          state_s = RECOVER;
        end else begin
          state_s = WAIT;
        end
      end
      RECOVER: state_s = IDLE;
      default: state_s = IDLE;
    endcase
    push_s = WrEn & (~Full | pop_s);
  end

  // FSM state register
  always_ff @(posedge CLK_Baudin) begin
    if (RstSch) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FIFO storage; stale contents are harmless because pointers are reset
  always_ff @(posedge CLK_Baudin) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= WrData;
    end
  end

  // FIFO pointers, occupancy and registered full/empty flags
  always_ff @(posedge CLK_Baudin) begin
    if (RstSch) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      Count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10: begin
          Count <= Count + CW'(1);
          Full  <= (Count == CW'(DEPTH - 1));
          Empty <= 1'b0;
        end
        2'b01: begin
          Count <= Count - CW'(1);
          Full  <= 1'b0;
          Empty <= (Count == CW'(1));
        end
        default: begin
          Count <= Count;
        end
      endcase
    end
  end

  // Transmitter-facing outputs, edge history, retry/timeout counters, sticky errors
  always_ff @(posedge CLK_Baudin) begin
    if (RstSch) begin
      DataIn      <= '0;
      NewData     <= 1'b0;
      TxRst       <= 1'b0;
      Busy        <= 1'b0;
      RetryErr    <= 1'b0;
      TimeoutErr  <= 1'b0;
      done_q_r    <= 1'b0;
      flag_q_r    <= 1'b0;
      retry_cnt_r <= '0;
      tmo_cnt_r   <= '0;
    end else begin
      done_q_r <= DoneTx;
      flag_q_r <= Flag_in;
      if (pop_s) begin
        DataIn <= mem_r[rd_ptr_r];
      end
      NewData <= (state_s == ISSUE);
      TxRst   <= (state_s == RECOVER);
      Busy    <= (state_s != IDLE);
      if (state_r == ISSUE) begin
        retry_cnt_r <= '0;
        tmo_cnt_r   <= '0;
      end else if (state_r == WAIT) begin
        if (tmo_cnt_r != TW'(TIMEOUT - 1)) begin
          tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end
        if (flag_rise_s && (retry_cnt_r != RW'(MAX_RETRY + 1))) begin
          retry_cnt_r <= retry_cnt_r + RW'(1);
        end
      end
      if (retry_set_s) begin
        RetryErr <= 1'b1;
      end else if (ErrClr) begin
        RetryErr <= 1'b0;
      end
      if (state_s == RECOVER) begin
        TimeoutErr <= 1'b1;
      end else if (ErrClr) begin
        TimeoutErr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: transmitter stub, issue scoreboard,
// table-driven FIFO fill, and hand-written retry/timeout/reset sequences.
module tb_uart_tx_scheduler;

  localparam int SIZE      = 32;
  localparam int DEPTH     = 8;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 64;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic            CLK_Baudin = 1'b0;
  logic            RstSch;
  logic [SIZE-1:0] WrData;
  logic            WrEn;
  logic            ErrClr;
  logic            DoneTx;
  logic            Flag_in;
  logic [SIZE-1:0] DataIn;
  logic            NewData;
  logic            TxRst;
  logic            Full;
  logic            Empty;
  logic [CW-1:0]   Count;
  logic            Busy;
  logic            RetryErr;
  logic            TimeoutErr;

  int n_total = 0;
  int n_pass  = 0;

  logic [SIZE-1:0] exp_q [$];
  logic [SIZE-1:0] mon_exp;
  logic [SIZE-1:0] di_prev = '0;
  logic            nd_prev = 1'b0;
  logic            tr_prev = 1'b0;
  logic            rst_edge = 1'b0;

  bit stub_en  = 1'b1;
  bit hold_low = 1'b0;
  int tx_len   = 35;

  typedef struct {
    logic [31:0]   data;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          full;
  } vec_t;

  vec_t tbl [10];

  uart_tx_scheduler #(
    .size(SIZE), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_Baudin(CLK_Baudin), .RstSch(RstSch), .WrData(WrData), .WrEn(WrEn),
    .ErrClr(ErrClr), .DoneTx(DoneTx), .Flag_in(Flag_in), .DataIn(DataIn),
    .NewData(NewData), .TxRst(TxRst), .Full(Full), .Empty(Empty), .Count(Count),
    .Busy(Busy), .RetryErr(RetryErr), .TimeoutErr(TimeoutErr)
  );

  always #5 CLK_Baudin = ~CLK_Baudin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK_Baudin);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input bit expect_issue);
    WrData = d;
    WrEn   = 1'b1;
    if (expect_issue) exp_q.push_back(d);
    step();
    WrEn = 1'b0;
  endtask

  task automatic wait_newdata(input string name, input int max_cyc);
    int c = 0;
    while (!NewData && c < max_cyc) begin
      step();
      c++;
    end
    check(name, 32'(NewData), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int c = 0;
    while ((Busy || exp_q.size() != 0) && c < max_cyc) begin
      step();
      c++;
    end
    check(name, 32'(Busy), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_DataIn"}, DataIn, 32'd0);
    check({tag, "_NewData"}, 32'(NewData), 32'd0);
    check({tag, "_TxRst"}, 32'(TxRst), 32'd0);
    check({tag, "_Full"}, 32'(Full), 32'd0);
    check({tag, "_Empty"}, 32'(Empty), 32'd1);
    check({tag, "_Count"}, 32'(Count), 32'd0);
    check({tag, "_Busy"}, 32'(Busy), 32'd0);
    check({tag, "_RetryErr"}, 32'(RetryErr), 32'd0);
    check({tag, "_TimeoutErr"}, 32'(TimeoutErr), 32'd0);
  endtask

  // Transmitter stub: drops DoneTx on each issue, raises it tx_len cycles later
  initial begin : stub
    int rem;
    rem    = 0;
    DoneTx = 1'b0;
    forever begin
      @(posedge CLK_Baudin);
      #2;
      if (stub_en) begin
        if (NewData) begin
          rem    = tx_len;
          DoneTx = 1'b0;
        end else if (rem > 0) begin
          rem--;
          if (rem == 0 && !hold_low) DoneTx = 1'b1;
        end
      end
    end
  end

  // Issue monitor: scoreboard pop on every NewData, pulse widths, DataIn stability
  initial begin : monitor
    forever begin
      @(posedge CLK_Baudin);
      rst_edge = RstSch;
      #1;
      if (NewData) begin
        check("newdata_width", 32'(nd_prev), 32'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_issue: DataIn=0x%0h issued, no word expected", DataIn);
        end else begin
          mon_exp = exp_q.pop_front();
          check("issue_data", DataIn, mon_exp);
        end
      end else if (!rst_edge && DataIn !== di_prev) begin
        n_total++;
        $display("FAIL datain_stable: changed 0x%0h -> 0x%0h without issue", di_prev, DataIn);
      end
      if (TxRst) check("txrst_width", 32'(tr_prev), 32'd0);
      nd_prev = NewData;
      tr_prev = TxRst;
      di_prev = DataIn;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  cyc;
    logic busy_before;

    for (int i = 0; i < 10; i++) begin
      tbl[i].data = 32'h2000_0000 + 32'(i);
      tbl[i].acc  = (i < 8);
      tbl[i].cnt  = CW'((i < 8) ? i + 1 : 8);
      tbl[i].full = (i >= 7);
    end

    RstSch = 1'b1; WrEn = 1'b0; WrData = '0; ErrClr = 1'b0; Flag_in = 1'b0;
    step(); step();
    check_reset_state("rst0");
    RstSch = 1'b0;
    step();

    // Single word: issue latency and completion
    push(32'hA5A5_1234, 1'b1);
    check("single_count", 32'(Count), 32'd1);
    check("single_empty", 32'(Empty), 32'd0);
    check("single_nd_early", 32'(NewData), 32'd0);
    step();
    check("single_nd", 32'(NewData), 32'd1);
    check("single_data", DataIn, 32'hA5A5_1234);
    check("single_busy", 32'(Busy), 32'd1);
    check("single_popped", 32'(Count), 32'd0);
    cyc = 0; busy_before = Busy;
    while (!DoneTx && cyc < 100) begin
      busy_before = Busy;
      step();
      cyc++;
    end
    check("single_done_seen", 32'(DoneTx), 32'd1);
    check("single_duration", 32'(cyc), 32'd36);
    check("single_busy_before", 32'(busy_before), 32'd1);
    check("single_busy_fall", 32'(Busy), 32'd0);

    // Fill and overflow with transmitter blocked and DoneTx left stale-high
    stub_en = 1'b0;
    push(32'h1000_0000, 1'b1);
    wait_newdata("fill_w0_issue", 5);
    step();
    for (int i = 0; i < 10; i++) begin
      WrData = tbl[i].data;
      WrEn   = 1'b1;
      if (tbl[i].acc) exp_q.push_back(tbl[i].data);
      step();
      WrEn = 1'b0;
      check($sformatf("fill_count_%0d", i), 32'(Count), 32'(tbl[i].cnt));
      check($sformatf("fill_full_%0d", i), 32'(Full), 32'(tbl[i].full));
      check($sformatf("fill_nd_%0d", i), 32'(NewData), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      check("stale_done_no_issue", 32'(NewData), 32'd0);
    end
    DoneTx = 1'b0;
    step();
    DoneTx = 1'b1;
    step();
    check("fill_release_idle", 32'(Busy), 32'd0);
    WrData = 32'h3000_0000;
    WrEn   = 1'b1;
    exp_q.push_back(32'h3000_0000);
    tx_len  = 40;
    stub_en = 1'b1;
    step();
    WrEn = 1'b0;
    check("pushpop_full_count", 32'(Count), 32'd8);
    check("pushpop_full_flag", 32'(Full), 32'd1);
    check("pushpop_issue", 32'(NewData), 32'd1);
    wait_idle("fill_drain", 2000);
    check("fill_drain_empty", 32'(Empty), 32'd1);
    check("fill_no_timeout", 32'(TimeoutErr), 32'd0);

    // Retry accounting; fifth pulse coincides with ErrClr and must win
    push(32'hC0DE_0001, 1'b1);
    wait_newdata("retry_issue", 5);
    step();
    for (int i = 0; i < 5; i++) begin
      Flag_in = 1'b1;
      ErrClr  = (i == 4);
      step();
      Flag_in = 1'b0;
      ErrClr  = 1'b0;
      step();
      check($sformatf("retry_err_%0d", i), 32'(RetryErr), 32'(i >= MAX_RETRY));
    end
    wait_idle("retry_complete", 200);
    check("retry_sticky", 32'(RetryErr), 32'd1);
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
    check("retry_clr", 32'(RetryErr), 32'd0);

    // Timeout recovery: TxRst after 64 WAIT cycles, next word two cycles later
    hold_low = 1'b1;
    push(32'hDEAD_0001, 1'b1);
    push(32'hDEAD_0002, 1'b1);
    wait_newdata("tmo_issue", 5);
    cyc = 0;
    while (!TxRst && cyc < 200) begin
      step();
      cyc++;
    end
    check("tmo_txrst", 32'(TxRst), 32'd1);
    check("tmo_cycles", 32'(cyc), 32'(TIMEOUT + 1));
    check("tmo_err", 32'(TimeoutErr), 32'd1);
    check("tmo_retry_clear", 32'(RetryErr), 32'd0);
    hold_low = 1'b0;
    tx_len   = 10;
    step();
    check("tmo_txrst_fall", 32'(TxRst), 32'd0);
    check("tmo_gap_nd", 32'(NewData), 32'd0);
    step();
    check("tmo_next_issue", 32'(NewData), 32'd1);
    wait_idle("tmo_next_done", 200);
    check("tmo_err_sticky", 32'(TimeoutErr), 32'd1);
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
    check("tmo_err_clr", 32'(TimeoutErr), 32'd0);

    // Reset mid-WAIT with three words queued
    hold_low = 1'b1;
    push(32'hBEEF_0000, 1'b1);
    push(32'hBEEF_0001, 1'b0);
    push(32'hBEEF_0002, 1'b0);
    push(32'hBEEF_0003, 1'b0);
    check("rstmid_count", 32'(Count), 32'd3);
    step(); step();
    check("rstmid_busy", 32'(Busy), 32'd1);
    RstSch = 1'b1;
    step(); step();
    RstSch = 1'b0;
    check_reset_state("rst1");
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst1_no_issue", 32'(NewData), 32'd0);
    end
    check("rst1_count_end", 32'(Count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
